// File: rtl/beep_pkg.sv
// beep_pkg: state encoding, event ids and per-event buzzer pattern table.
package beep_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
  localparam logic [1:0] ID_COIN = 2'd0;
  localparam logic [1:0] ID_SELECT = 2'd1;
  localparam logic [1:0] ID_DISPENSE = 2'd2;
  localparam logic [1:0] ID_FAULT = 2'd3;
  localparam logic [1:0] PULSES_0 = 2'd1;
  localparam logic [1:0] PULSES_1 = 2'd2;
  localparam logic [1:0] PULSES_2 = 2'd1;
  localparam logic [1:0] PULSES_3 = 2'd3;
  localparam logic [2:0] ON_TICKS_0 = 3'd1;
  localparam logic [2:0] ON_TICKS_1 = 3'd1;
  localparam logic [2:0] ON_TICKS_2 = 3'd5;
  localparam logic [2:0] ON_TICKS_3 = 3'd2;
  localparam logic [2:0] OFF_TICKS_0 = 3'd0;
  localparam logic [2:0] OFF_TICKS_1 = 3'd1;
  localparam logic [2:0] OFF_TICKS_2 = 3'd0;
  localparam logic [2:0] OFF_TICKS_3 = 3'd2;
  function automatic logic [1:0] pulses(input logic [1:0] id);
    return id == ID_FAULT ? PULSES_3 : id == ID_DISPENSE ? PULSES_2 :
           id == ID_SELECT ? PULSES_1 : PULSES_0;
  endfunction
  function automatic logic [2:0] on_ticks(input logic [1:0] id);
    return id == ID_FAULT ? ON_TICKS_3 : id == ID_DISPENSE ? ON_TICKS_2 :
           id == ID_SELECT ? ON_TICKS_1 : ON_TICKS_0;
  endfunction
  function automatic logic [2:0] off_ticks(input logic [1:0] id);
    return id == ID_FAULT ? OFF_TICKS_3 : id == ID_DISPENSE ? OFF_TICKS_2 :
           id == ID_SELECT ? OFF_TICKS_1 : OFF_TICKS_0;
  endfunction
  function automatic logic [1:0] hi_bit(input logic [3:0] p);
    return p[3] ? 2'd3 : p[2] ? 2'd2 : p[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/beep_tick_gen.sv
// beep_tick_gen: one-cycle tick every TICK_CYCLES clocks, restarted by clr.
module beep_tick_gen #(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  logic [CW-1:0] r_cnt;
  assign tick = r_cnt == CW'(TICK_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (clr || tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/beep_scheduler.sv
// beep_scheduler: queues buzzer events, grants highest priority, plays its
// on/off pattern in ticks with an enforced silent gap between patterns.
module beep_scheduler
  import beep_pkg::*;
#(
  parameter int TICK_CYCLES = 5_000_000,
  parameter int GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] req,
  output logic       beep,
  output logic       busy,
  output logic [1:0] cur_id,
  output logic       done
);
  localparam state_t END_ST = GAP_TICKS == 0 ? IDLE : GAP;
  state_t     r_state;
  logic [3:0] r_pend;
  logic [2:0] r_dur;
  logic [1:0] r_pl;
  logic [1:0] r_cur;
  logic       r_beep;
  logic       r_done;
  logic       w_tick;
  logic       w_last;
  logic       w_abort;
  logic       w_grant;
  logic       w_clr;
  logic [1:0] w_id;
  logic [3:0] w_mask;
  assign w_id = hi_bit(r_pend);
  assign w_grant = r_state == IDLE && |r_pend;
  assign w_mask = w_grant ? 4'd1 << w_id : 4'd0;
  assign w_last = w_tick && r_dur == 3'd1;
  // a queued fault cuts short any other pattern; the victim is not re-queued
  assign w_abort = (r_state == ON || r_state == OFF) && r_pend[ID_FAULT] && r_cur != ID_FAULT;
  assign w_clr = !enable || r_state == IDLE || w_abort || w_last;
  assign beep = r_beep;
  assign busy = r_state != IDLE;
  assign cur_id = r_cur;
  assign done = r_done;
  beep_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk(clk),
    .rst_n(rst_n),
    .clr(w_clr),
    .tick(w_tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend <= '0;
      r_dur <= '0;
      r_pl <= '0;
      r_cur <= '0;
      r_beep <= 1'b1;
      r_done <= 1'b0;
    end else if (!enable) begin
      r_state <= IDLE;
      r_pend <= '0;
      r_beep <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pend <= (r_pend & ~w_mask) | req;
      case (r_state)
        IDLE: if (w_grant) begin
          r_cur <= w_id;
          r_pl <= pulses(w_id) - 2'd1;
          r_dur <= on_ticks(w_id);
          r_beep <= 1'b0;
          r_state <= ON;
        end
        ON: if (w_abort) begin
          r_beep <= 1'b1;
          r_dur <= 3'(GAP_TICKS);
          r_state <= END_ST;
        end else if (w_last) begin
          r_beep <= 1'b1;
          r_dur <= r_pl != 2'd0 ? off_ticks(r_cur) : 3'(GAP_TICKS);
          r_done <= r_pl == 2'd0;
          r_state <= r_pl != 2'd0 ? OFF : END_ST;
        end else if (w_tick) r_dur <= r_dur - 3'd1;
        OFF: if (w_abort) begin
          r_dur <= 3'(GAP_TICKS);
          r_state <= END_ST;
        end else if (w_last) begin
          r_beep <= 1'b0;
          r_pl <= r_pl - 2'd1;
          r_dur <= on_ticks(r_cur);
          r_state <= ON;
        end else if (w_tick) r_dur <= r_dur - 3'd1;
        GAP: if (w_last) r_state <= IDLE;
          else if (w_tick) r_dur <= r_dur - 3'd1;
        default: r_state <= IDLE;
      endcase
    end
endmodule
